// File: rtl/gpu_msg_pkg.sv
// Shared definitions for the scheduler-to-core message stream.
//   state_t      receive FSM states
//   IFNUM_MASK   header word 0 bits [5:0]: instruction frame count
//   FENCE_MASK   header word 0 bits [7:6]: fence field
//   FENCE_*      fence encodings (exported only, no effect on sequencing)
//   DEF_*        default stream geometry
//   hdr_fence()  extracts the fence field from a header word
package gpu_msg_pkg;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        HDR2  = 3'd2,
        R0    = 3'd3,
        INSTR = 3'd4,
        DONE  = 3'd5,
        RUN   = 3'd6
    } state_t;

    localparam logic [5:0]  IFNUM_MASK  = 6'h3F;
    localparam logic [15:0] FENCE_MASK  = 16'h00C0;
    localparam int          FENCE_SHIFT = 6;

    localparam logic [1:0] FENCE_NONE = 2'b00;
    localparam logic [1:0] FENCE_ACQ  = 2'b01;
    localparam logic [1:0] FENCE_REL  = 2'b10;

    localparam int DEF_FRAME_WORDS = 16;
    localparam int DEF_R0_DEPTH    = 8;

    function automatic logic [1:0] hdr_fence(input logic [15:0] w);
        return 2'((w & FENCE_MASK) >> FENCE_SHIFT);
    endfunction

endpackage

// File: rtl/msg_word_counter.sv
// Loadable word counter with terminal-count flag.
//   clk, reset  clock, synchronous active-high reset (count -> 0)
//   clr         force count to 0 (wins over en)
//   en          advance count by one
//   last_val    terminal value compared against the current count
//   count       current count
//   at_last     count == last_val
module msg_word_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] count,
    output logic         at_last
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_last = (count_q == last_val);

endmodule

// File: rtl/core_msg_receiver.sv
// Per-core receive stage downstream of the scheduler broadcast stream.
// Stream per task: header, exec mask, r0 init vector, R0_DEPTH r0 words,
// then if_num * FRAME_WORDS instruction words.
//   msg_valid/msg_data/msg_ready  inbound word handshake
//   core_busy / core_ready        core status in, receiver idle out
//   ibuf_we/ibuf_addr/ibuf_wdata  registered instruction buffer write port
//   r0_value/r0_valid             r0 for the current task
//   fence                         fence field of the last header
//   start                         one-cycle start pulse
//   ovf_err                       sticky instruction buffer overflow
//   state_dbg                     current FSM state
// Optional macro CORE_MSG_RECV_STATS_EN adds tasks_run / tasks_skipped.
//
// Handshake: a word is consumed on any cycle with msg_valid & msg_ready.
// msg_ready depends only on the FSM state (low only in RUN), never on
// msg_valid, and non-selected cores keep consuming so they never stall
// the broadcast.
module core_msg_receiver
    import gpu_msg_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int CORE_NUM    = 16,
    parameter int MSG_WIDTH   = 16,
    parameter int R0_DEPTH    = DEF_R0_DEPTH,
    parameter int IBUF_DEPTH  = 256,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          msg_valid,
    input  logic [MSG_WIDTH-1:0]          msg_data,
    output logic                          msg_ready,
    input  logic                          core_busy,
    output logic                          core_ready,
    output logic                          ibuf_we,
    output logic [$clog2(IBUF_DEPTH)-1:0] ibuf_addr,
    output logic [MSG_WIDTH-1:0]          ibuf_wdata,
    output logic [MSG_WIDTH-1:0]          r0_value,
    output logic                          r0_valid,
    output logic [1:0]                    fence,
    output logic                          start,
    output logic                          ovf_err,
`ifdef CORE_MSG_RECV_STATS_EN
    output logic [15:0]                   tasks_run,
    output logic [15:0]                   tasks_skipped,
`endif
    output logic [2:0]                    state_dbg
);

    localparam int AW = $clog2(IBUF_DEPTH);
    localparam int CW = 10;
    localparam logic [CW-1:0] R0_LAST  = CW'(R0_DEPTH - 1);
    localparam logic [CW-1:0] R0_IDX   = CW'(CORE_ID % R0_DEPTH);
    localparam logic [CW-1:0] FW       = CW'(FRAME_WORDS);
    localparam logic [CW:0]   IBUF_LIM = (CW+1)'(IBUF_DEPTH);

    state_t                 state_q, state_d;
    logic [5:0]             if_num_q, if_num_d;
    logic [1:0]             fence_q, fence_d;
    logic                   mine_q, mine_d;
    logic                   r0_sel_q, r0_sel_d;
    logic [MSG_WIDTH-1:0]   r0_value_q, r0_value_d;
    logic                   r0_valid_q, r0_valid_d;
    logic                   ibuf_we_q, ibuf_we_d;
    logic [AW-1:0]          ibuf_addr_q, ibuf_addr_d;
    logic [MSG_WIDTH-1:0]   ibuf_wdata_q, ibuf_wdata_d;
    logic                   ovf_q, ovf_d;

    logic                   xfer;
    logic [CORE_NUM-1:0]    mask_word;
    logic                   id_bit;
    logic [15:0]            hdr_word;
    logic [CW-1:0]          r0_cnt, w_cnt, w_last;
    logic                   r0_at_last, w_at_last;

    assign msg_ready = (state_q != RUN);
    assign xfer      = msg_valid & msg_ready;
    assign mask_word = msg_data[CORE_NUM-1:0];
    assign id_bit    = mask_word[CORE_ID];
    assign hdr_word  = 16'(msg_data);
    // Last instruction word index; only consulted when if_num != 0.
    assign w_last    = CW'({4'b0000, if_num_q} * FW) - CW'(1);

    msg_word_counter #(.W(CW)) u_r0_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      ((state_q == HDR2) & xfer),
        .en       ((state_q == R0) & xfer),
        .last_val (R0_LAST),
        .count    (r0_cnt),
        .at_last  (r0_at_last)
    );

    msg_word_counter #(.W(CW)) u_w_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      ((state_q == R0) & xfer & r0_at_last),
        .en       ((state_q == INSTR) & xfer),
        .last_val (w_last),
        .count    (w_cnt),
        .at_last  (w_at_last)
    );

    always_comb begin
        state_d      = state_q;
        if_num_d     = if_num_q;
        fence_d      = fence_q;
        mine_d       = mine_q;
        r0_sel_d     = r0_sel_q;
        r0_value_d   = r0_value_q;
        r0_valid_d   = r0_valid_q;
        ibuf_we_d    = 1'b0;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_wdata_d = ibuf_wdata_q;
        ovf_d        = ovf_q;
        case (state_q)
            HDR0: if (xfer) begin
                if_num_d   = hdr_word[5:0] & IFNUM_MASK;
                fence_d    = hdr_fence(hdr_word);
                r0_valid_d = 1'b0;
                state_d    = HDR1;
            end
            HDR1: if (xfer) begin
                mine_d  = id_bit;
                state_d = HDR2;
            end
            HDR2: if (xfer) begin
                r0_sel_d = id_bit;
                state_d  = R0;
            end
            R0: if (xfer) begin
                if ((r0_cnt == R0_IDX) && mine_q && r0_sel_q) begin
                    r0_value_d = msg_data;
                    r0_valid_d = 1'b1;
                end
                if (r0_at_last) begin
                    state_d = (if_num_q != 6'd0) ? INSTR : HDR0;
                end
            end
            INSTR: if (xfer) begin
                if (mine_q) begin
                    // Words past the buffer end are dropped but flagged.
                    if ({1'b0, w_cnt} < IBUF_LIM) begin
                        ibuf_we_d    = 1'b1;
                        ibuf_addr_d  = w_cnt[AW-1:0];
                        ibuf_wdata_d = msg_data;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (w_at_last) begin
                    state_d = mine_q ? DONE : HDR0;
                end
            end
            DONE: state_d = RUN;
            // The DONE cycle is not checked, giving the core one cycle to
            // raise core_busy after start.
            RUN: if (!core_busy) state_d = HDR0;
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HDR0;
            if_num_q     <= '0;
            fence_q      <= '0;
            mine_q       <= 1'b0;
            r0_sel_q     <= 1'b0;
            r0_value_q   <= '0;
            r0_valid_q   <= 1'b0;
            ibuf_we_q    <= 1'b0;
            ibuf_addr_q  <= '0;
            ibuf_wdata_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            if_num_q     <= if_num_d;
            fence_q      <= fence_d;
            mine_q       <= mine_d;
            r0_sel_q     <= r0_sel_d;
            r0_value_q   <= r0_value_d;
            r0_valid_q   <= r0_valid_d;
            ibuf_we_q    <= ibuf_we_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_wdata_q <= ibuf_wdata_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef CORE_MSG_RECV_STATS_EN
    logic [15:0] tasks_run_q, tasks_run_d;
    logic [15:0] tasks_skipped_q, tasks_skipped_d;
    logic        skip_end;

    // A task ends without start when r0 closes with no frames, or the
    // frames close for a core that was not selected.
    assign skip_end = xfer &
                      (((state_q == R0) & r0_at_last & (if_num_q == 6'd0)) |
                       ((state_q == INSTR) & w_at_last & !mine_q));

    always_comb begin
        tasks_run_d     = tasks_run_q;
        tasks_skipped_d = tasks_skipped_q;
        if (state_q == DONE) tasks_run_d = tasks_run_q + 16'd1;
        if (skip_end)        tasks_skipped_d = tasks_skipped_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tasks_run_q     <= '0;
            tasks_skipped_q <= '0;
        end else begin
            tasks_run_q     <= tasks_run_d;
            tasks_skipped_q <= tasks_skipped_d;
        end
    end

    assign tasks_run     = tasks_run_q;
    assign tasks_skipped = tasks_skipped_q;
`endif

    assign core_ready = (state_q == HDR0) & !core_busy;
    assign ibuf_we    = ibuf_we_q;
    assign ibuf_addr  = ibuf_addr_q;
    assign ibuf_wdata = ibuf_wdata_q;
    assign r0_value   = r0_value_q;
    assign r0_valid   = r0_valid_q;
    assign fence      = fence_q;
    assign start      = (state_q == DONE);
    assign ovf_err    = ovf_q;
    assign state_dbg  = state_q;

endmodule
